fifo_wr_arb: RTL and testbench
==============================

Name: fifo_wr_arb

Overview:
Two-requester write arbiter in front of the 4-entry FIFO controller and its storage.
- Grants FIFO write ownership round-robin, with optional bounded bursts (lock).
- Drives the FIFO's data_in_valid and write data, and tags each beat with its source.
- Watches fifo_full and the FIFO error flag; stops all writes on error.

Parameters:
DATA_W, 16, width of each requester's write data and of fifo_data.
MAX_BURST, 4, maximum beats accepted per grant while lock is held (legal range 1..15).

Ports:
clk  in  1  system clock; all state on rising edge.
rst  in  1  reset; one clock; reset is asynchronous and active-low.
req0  in  1  requester 0 has a beat on data0.
lock0  in  1  requester 0 requests to keep the grant for a burst.
data0  in  DATA_W  requester 0 write data.
ack0  out  1  requester 0 beat accepted this cycle.
req1/lock1/data1/ack1: same as above, for requester 1.
fifo_full  in  1  FIFO controller full flag.
fifo_err  in  1  FIFO controller error flag.
data_in_valid  out  1  write strobe to the FIFO controller.
fifo_data  out  DATA_W  write data to the FIFO storage.
src_id  out  1  source of the current beat (0/1).
arb_err  out  1  sticky error flag.

Behaviour:
- States (2-bit): IDLE=00, OWN0=01, OWN1=10, HALT=11.
- Registers:
  - state
  - rr_last (last served requester)
  - beat_cnt (4-bit)
  - arb_err
- Reset (rst=0, asynchronous): state=IDLE, rr_last=1 (requester 0 wins the first tie), beat_cnt=0, arb_err=0.
- Output values forced by reset: data_in_valid=0, ack0=ack1=0, fifo_data=0, src_id=0.
- IDLE:
  - No write occurs in this state.
  - If only one requester asserts req, go to that requester's OWN state.
  - If both assert req, go to the OWN state of the requester that is not rr_last.
  - Arbitration latency is one cycle from req to the first possible ack.
- OWNx, write path (combinational):
  - data_in_valid = ackx = reqx & ~fifo_full.
  - fifo_data = datax, src_id = x.
  - When not writing: fifo_data=0, src_id=0.
- OWNx, counting:
  - On an accepted beat, beat_cnt increments.
  - Release occurs after an accepted beat when lockx=0 or beat_cnt==MAX_BURST-1.
  - Release also occurs in any cycle where reqx=0.
- Release action:
  - Set rr_last=x and clear beat_cnt.
  - Next state = OWN(other) if the other requester's req=1.
  - Otherwise next state = OWNx if reqx=1 (back-to-back, no bubble).
  - Otherwise next state = IDLE.
- Full FIFO:
  - While fifo_full=1 and reqx=1, the grant is held regardless of lock.
  - beat_cnt holds and no ack is issued.
- Burst of MAX_BURST=1: every beat releases, giving strict alternation under contention.
- Error:
  - fifo_err=1 in any state moves state to HALT on the next edge, with priority over all other transitions.
  - In HALT: arb_err=1, all acks/data_in_valid=0. HALT is left only via reset.
- Ack timing: ack is combinational in the same cycle as data_in_valid. A requester may change its data or req only after a cycle with ack=1, or when it abandons the request.
- Never more than one ack in a cycle. Never data_in_valid while fifo_full=1.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - Adds outputs beats0 and beats1 (8-bit each).
  - Each counts accepted beats for its requester and saturates at 255.
  - Both clear on reset and freeze in HALT.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg:
  - State encodings IDLE/OWN0/OWN1/HALT.
  - Source ID constants SRC0=0, SRC1=1.
  - Beat counter width (4) and stats counter width (8).
- Sub-module rr_pick2 (combinational):
  - Inputs req0, req1, rr_last.
  - Outputs a grant-valid bit and the winner ID.
  - Used in IDLE and on release.

Test Plan:
- Reset with req0=req1=1 -> cycle 1 is IDLE with no ack; cycle 2 OWN0, ack0=1, src_id=0, fifo_data=data0.
- Both requesters request, lock0=lock1=0, fifo_full=0 -> acks alternate 0,1,0,1 with no idle cycles between beats.
- lock0=1 held, MAX_BURST=4, req1=1 -> exactly 4 consecutive ack0, then ack1.
- OWN1 with fifo_full=1 for 3 cycles -> no ack, data_in_valid=0, grant held; first ack1 in the cycle fifo_full falls.
- fifo_err pulses for 1 cycle mid-burst -> next cycle arb_err=1 and all acks 0 forever; rst low->high clears arb_err and returns to IDLE.
- With FIFO_ARB_STATS_EN: 300 accepted beats from requester 0 -> beats0=255, beats1=0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the two-requester FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10,
    HALT = 2'b11
  } arb_state_e;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  localparam int BEAT_CNT_W = 4;
  localparam int STATS_W    = 8;

  function automatic arb_state_e own_state(input logic id);
    return id ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick2.sv
// Two-way round-robin pick: the requester that was not served last wins a tie.
module rr_pick2
  import fifo_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic gnt_vld,
  output logic gnt_id
);

  always_comb begin
    gnt_vld = req0 | req1;
    gnt_id  = SRC0;
    if (req0 && req1) begin
      gnt_id = ~rr_last;
    end else if (req1) begin
      gnt_id = SRC1;
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter with bounded lock bursts in front of the 4-entry FIFO.
// FIFO_ARB_STATS_EN adds saturating per-requester accepted-beat counters.
//
// state | meaning
// IDLE  | no owner; arbitrate, no write this cycle
// OWN0  | requester 0 owns the FIFO write port
// OWN1  | requester 1 owns the FIFO write port
// HALT  | FIFO error seen; writes blocked until reset
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              lock0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic              lock1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  input  logic              fifo_full,
  input  logic              fifo_err,
  output logic              data_in_valid,
  output logic [DATA_W-1:0] fifo_data,
  output logic              src_id,
`ifdef FIFO_ARB_STATS_EN
  output logic [STATS_W-1:0] beats0,
  output logic [STATS_W-1:0] beats1,
`endif
  output logic              arb_err
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_BURST - 1);

  arb_state_e            state_q, state_d;
  logic                  rr_last_q, rr_last_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                  arb_err_q, arb_err_d;

  logic pick_last, pick_vld, pick_id;
  logic owning, own_id, own_req, own_lock, wr_en, release_grant;

  // While owning, the release pick treats the current owner as last served.
  always_comb begin
    owning    = (state_q == OWN0) || (state_q == OWN1);
    own_id    = (state_q == OWN1);
    own_req   = own_id ? req1  : req0;
    own_lock  = own_id ? lock1 : lock0;
    pick_last = owning ? own_id : rr_last_q;
  end

  rr_pick2 u_pick (
    .req0    (req0),
    .req1    (req1),
    .rr_last (pick_last),
    .gnt_vld (pick_vld),
    .gnt_id  (pick_id)
  );

  always_comb begin
    wr_en         = owning & own_req & ~fifo_full;
    data_in_valid = wr_en;
    ack0          = wr_en & ~own_id;
    ack1          = wr_en & own_id;
    src_id        = wr_en ? own_id : SRC0;
    fifo_data     = '0;
    if (wr_en) begin
      fifo_data = own_id ? data1 : data0;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    beat_cnt_d    = beat_cnt_q;
    arb_err_d     = arb_err_q;
    release_grant = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = own_state(pick_id);
        end
      end
      OWN0, OWN1: begin
        // A full FIFO with req held falls through here: grant and count hold.
        if (!own_req) begin
          release_grant = 1'b1;
        end else if (wr_en) begin
          if (!own_lock || (beat_cnt_q == LAST_BEAT)) begin
            release_grant = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
        if (release_grant) begin
          rr_last_d  = own_id;
          beat_cnt_d = '0;
          state_d    = pick_vld ? own_state(pick_id) : IDLE;
        end
      end
      default: begin
        arb_err_d = 1'b1;
      end
    endcase

    if (fifo_err) begin
      state_d   = HALT;
      arb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_last_q  <= SRC1;
      beat_cnt_q <= '0;
      arb_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      beat_cnt_q <= beat_cnt_d;
      arb_err_q  <= arb_err_d;
    end
  end

  assign arb_err = arb_err_q;

`ifdef FIFO_ARB_STATS_EN
  logic [STATS_W-1:0] beats0_q, beats0_d;
  logic [STATS_W-1:0] beats1_q, beats1_d;

  // No acks are issued in HALT, so the counters freeze there on their own.
  always_comb begin
    beats0_d = beats0_q;
    beats1_d = beats1_q;
    if (ack0 && (beats0_q != '1)) begin
      beats0_d = beats0_q + STATS_W'(1);
    end
    if (ack1 && (beats1_q != '1)) begin
      beats1_d = beats1_q + STATS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beats0_q <= '0;
      beats1_q <= '0;
    end else begin
      beats0_q <= beats0_d;
      beats1_q <= beats1_d;
    end
  end

  assign beats0 = beats0_q;
  assign beats1 = beats1_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed literal scenarios plus a random run
// checked every cycle against an owner/burst-count behavioural model.
module tb_fifo_wr_arb;

  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 4;

  logic              clk;
  logic              rst;
  logic              req0, lock0, ack0;
  logic              req1, lock1, ack1;
  logic [DATA_W-1:0] data0, data1;
  logic              fifo_full, fifo_err;
  logic              data_in_valid;
  logic [DATA_W-1:0] fifo_data;
  logic              src_id;
  logic              arb_err;
`ifdef FIFO_ARB_STATS_EN
  logic [7:0]        beats0, beats1;
`endif

  int total = 0;
  int bad   = 0;

  fifo_wr_arb #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0          (req0),
    .lock0         (lock0),
    .data0         (data0),
    .ack0          (ack0),
    .req1          (req1),
    .lock1         (lock1),
    .data1         (data1),
    .ack1          (ack1),
    .fifo_full     (fifo_full),
    .fifo_err      (fifo_err),
    .data_in_valid (data_in_valid),
    .fifo_data     (fifo_data),
    .src_id        (src_id),
`ifdef FIFO_ARB_STATS_EN
    .beats0        (beats0),
    .beats1        (beats1),
`endif
    .arb_err       (arb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner -1 means nobody owns the port; burst counts beats taken in this grant.
  int m_own   = -1;
  int m_last  = 1;
  int m_burst = 0;
  bit m_halt  = 1'b0;
  bit m_err   = 1'b0;
  int m_n0    = 0;
  int m_n1    = 0;

  function automatic bit model_wr();
    bit [1:0] rq;
    rq = {req1, req0};
    return !m_halt && (m_own >= 0) && rq[m_own] && !fifo_full;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_own   <= -1;
      m_last  <= 1;
      m_burst <= 0;
      m_halt  <= 1'b0;
      m_err   <= 1'b0;
      m_n0    <= 0;
      m_n1    <= 0;
    end else begin
      int own, last, burst;
      bit wr, rel;
      bit [1:0] rq, lk;
      rq    = {req1, req0};
      lk    = {lock1, lock0};
      own   = m_own;
      last  = m_last;
      burst = m_burst;
      wr    = model_wr();
      rel   = 1'b0;
      if (wr && own == 0 && m_n0 < 255) m_n0 <= m_n0 + 1;
      if (wr && own == 1 && m_n1 < 255) m_n1 <= m_n1 + 1;
      if (fifo_err) begin
        m_halt <= 1'b1;
        m_err  <= 1'b1;
        m_own  <= -1;
      end else if (!m_halt) begin
        if (own < 0) begin
          if (rq == 2'b11) own = 1 - last;
          else if (rq[0]) own = 0;
          else if (rq[1]) own = 1;
        end else begin
          if (!rq[own]) rel = 1'b1;
          else if (wr) begin
            burst++;
            if (!lk[own] || burst == MAX_BURST) rel = 1'b1;
          end
          if (rel) begin
            last  = own;
            burst = 0;
            if (rq[1 - last]) own = 1 - last;
            else if (rq[last]) own = last;
            else own = -1;
          end
        end
        m_own   <= own;
        m_last  <= last;
        m_burst <= burst;
      end
    end
  end

  always @(negedge clk) begin
    bit e_wr;
    logic [DATA_W-1:0] e_data;
    e_wr   = model_wr();
    e_data = '0;
    if (e_wr) e_data = (m_own == 1) ? data1 : data0;
    chk("cyc_ack0",  {31'd0, ack0},          {31'd0, e_wr && m_own == 0});
    chk("cyc_ack1",  {31'd0, ack1},          {31'd0, e_wr && m_own == 1});
    chk("cyc_valid", {31'd0, data_in_valid}, {31'd0, e_wr});
    chk("cyc_data",  {16'd0, fifo_data},     {16'd0, e_data});
    chk("cyc_src",   {31'd0, src_id},        {31'd0, e_wr && m_own == 1});
    chk("cyc_err",   {31'd0, arb_err},       {31'd0, m_err});
`ifdef FIFO_ARB_STATS_EN
    chk("cyc_beats0", {24'd0, beats0}, m_n0);
    chk("cyc_beats1", {24'd0, beats1}, m_n1);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic r0, input logic l0, input logic r1, input logic l1,
                        input logic full);
    req0 = r0; lock0 = l0; req1 = r1; lock1 = l1; fifo_full = full;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fifo_err = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int halt_cycles;
    logic a0, a1;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0);
    fifo_err = 1'b0;
    data0 = 16'hA5A5;
    data1 = 16'h5A5A;

    // Reset with both requesting, then plain alternation.
    set_in(1, 0, 1, 0, 0);
    do_reset();
    look();
    chk("rst_idle_ack0", {31'd0, ack0}, 0);
    chk("rst_idle_ack1", {31'd0, ack1}, 0);
    chk("rst_idle_valid", {31'd0, data_in_valid}, 0);
    chk("rst_idle_data", {16'd0, fifo_data}, 0);
    chk("rst_arb_err", {31'd0, arb_err}, 0);
    tick(); look();
    chk("first_ack0", {31'd0, ack0}, 1);
    chk("first_src", {31'd0, src_id}, 0);
    chk("first_data", {16'd0, fifo_data}, 32'hA5A5);
    tick(); look();
    chk("alt_ack1", {31'd0, ack1}, 1);
    chk("alt_data1", {16'd0, fifo_data}, 32'h5A5A);
    chk("alt_src1", {31'd0, src_id}, 1);
    tick(); look();
    chk("alt_ack0_b", {31'd0, ack0}, 1);
    tick(); look();
    chk("alt_ack1_b", {31'd0, ack1}, 1);

    // Locked burst of MAX_BURST beats from requester 0, then requester 1.
    set_in(1, 1, 1, 0, 0);
    do_reset();
    for (int i = 0; i < MAX_BURST; i++) begin
      tick(); look();
      chk("burst_ack0", {31'd0, ack0}, 1);
    end
    tick(); look();
    chk("burst_end_ack1", {31'd0, ack1}, 1);
    chk("burst_end_ack0", {31'd0, ack0}, 0);

    // Full FIFO holds requester 1's grant even with requester 0 waiting.
    set_in(0, 0, 1, 0, 1);
    do_reset();
    tick();
    req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("full_ack1", {31'd0, ack1}, 0);
      chk("full_ack0", {31'd0, ack0}, 0);
      chk("full_valid", {31'd0, data_in_valid}, 0);
      tick();
    end
    fifo_full = 1'b0;
    look();
    chk("unfull_ack1", {31'd0, ack1}, 1);
    chk("unfull_ack0", {31'd0, ack0}, 0);

    // Error pulse mid-burst halts everything until reset.
    set_in(1, 1, 1, 1, 0);
    do_reset();
    tick();
    tick();
    fifo_err = 1'b1;
    tick();
    fifo_err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      look();
      chk("halt_err", {31'd0, arb_err}, 1);
      chk("halt_acks", {30'd0, ack1, ack0}, 0);
      tick();
    end
    rst = 1'b0;
    #1;
    chk("halt_rst_err", {31'd0, arb_err}, 0);
    tick();
    rst = 1'b1;
    tick(); look();
    chk("after_halt_ack0", {31'd0, ack0}, 1);

`ifdef FIFO_ARB_STATS_EN
    set_in(1, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 305; i++) tick();
    look();
    chk("stats_beats0", {24'd0, beats0}, 255);
    chk("stats_beats1", {24'd0, beats1}, 0);
`endif

    // Random traffic; data only changes after an ack or while idle.
    set_in(0, 0, 0, 0, 0);
    do_reset();
    halt_cycles = 0;
    a0 = 1'b0;
    a1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!req0 || a0) begin
        data0 = DATA_W'($urandom);
        req0  = ($urandom_range(0, 9) < 6);
      end else if ($urandom_range(0, 19) == 0) begin
        req0 = 1'b0;
      end
      if (!req1 || a1) begin
        data1 = DATA_W'($urandom);
        req1  = ($urandom_range(0, 9) < 6);
      end else if ($urandom_range(0, 19) == 0) begin
        req1 = 1'b0;
      end
      lock0     = $urandom_range(0, 1);
      lock1     = $urandom_range(0, 1);
      fifo_full = ($urandom_range(0, 3) == 0);
      fifo_err  = ($urandom_range(0, 499) == 0);
      look();
      a0 = ack0;
      a1 = ack1;
      tick();
      if (m_halt) halt_cycles++;
      if (halt_cycles > 4) begin
        halt_cycles = 0;
        a0 = 1'b0;
        a1 = 1'b0;
        do_reset();
      end
    end

    fifo_err = 1'b0;
    look();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
